// File: rtl/pcileech_com_tx_arb_pkg.sv
// ---------------------------------------------------------------------------
// pcileech_com_pkg
// Shared types and constants for the communication-core TX arbitration path.
//   COM_PAD_DW  : host-side resync/filler DWORD, discarded by the host parser
//   COM_WORD_DW : DWORDs per 256-bit com-core word
//   arb_state_t : TX arbiter FSM states
//   com_dw_t    : one 32-bit DWORD
// ---------------------------------------------------------------------------
package pcileech_com_pkg;

  localparam logic [31:0] COM_PAD_DW  = 32'h66665555;
  localparam int          COM_WORD_DW = 8;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_COLLECT,
    ARB_EMIT
  } arb_state_t;

  typedef logic [31:0] com_dw_t;

endpackage

// File: rtl/pcileech_com_tx_arb_if.sv
// ---------------------------------------------------------------------------
// pcileech_com_tx_arb_if
// Bundles the requester side (NUM_SRC x 32-bit valid/ready/last streams) and
// the TX FIFO write side (256-bit word, write strobe, FIFO ready).
//   master : requesters + TX FIFO (drives src_*, out_ready)
//   slave  : the arbiter          (drives src_ready, out_data, out_wr_en)
// ---------------------------------------------------------------------------
interface pcileech_com_tx_arb_if #(
  parameter int NUM_SRC = 4
) ();

  logic [NUM_SRC*32-1:0] src_data;
  logic [NUM_SRC-1:0]    src_valid;
  logic [NUM_SRC-1:0]    src_last;
  logic [NUM_SRC-1:0]    src_ready;
  logic [255:0]          out_data;
  logic                  out_wr_en;
  logic                  out_ready;

  modport master (
    output src_data, src_valid, src_last, out_ready,
    input  src_ready, out_data, out_wr_en
  );

  modport slave (
    input  src_data, src_valid, src_last, out_ready,
    output src_ready, out_data, out_wr_en
  );

endinterface

// File: rtl/pcileech_com_tx_arb_rr_pick.sv
// ---------------------------------------------------------------------------
// pcileech_rr_pick
// Combinational round-robin finder: returns the first requester found when
// searching upward from last_i+1, wrapping at N.
//   req_i  : request vector
//   last_i : index granted last time
//   idx_o  : selected index (0 when nothing requests)
//   any_o  : at least one request present
// ---------------------------------------------------------------------------
module pcileech_rr_pick #(
  parameter int N  = 4,
  parameter int IW = 3
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] last_i,
  output logic [IW-1:0] idx_o,
  output logic          any_o
);

  always_comb begin
    logic [IW-1:0] cand;
    logic [N-1:0]  onehot;
    idx_o  = '0;
    any_o  = 1'b0;
    cand   = '0;
    onehot = '0;
    // Offset N lands on last_i itself, so a lone requester can be re-granted.
    for (int off = 1; off <= N; off++) begin
      cand   = IW'((int'(last_i) + off) % N);
      onehot = N'(1) << cand;
      if (!any_o && ((req_i & onehot) != '0)) begin
        any_o = 1'b1;
        idx_o = cand;
      end
    end
  end

endmodule

// File: rtl/pcileech_com_tx_arb.sv
// ---------------------------------------------------------------------------
// pcileech_com_tx_arb
// Shares the 256-bit com-core TX FIFO write port among NUM_SRC 32-bit packet
// requesters. Round-robin grant held for a whole packet; DWORDs are packed in
// acceptance order into 8 lanes, unused lanes filled with PAD_DW.
//   clk, rst          : clock, synchronous active-high reset
//   bus (slave)       : src_data/valid/last/ready, out_data/wr_en/ready
//   grant_idx         : currently granted source
//   busy              : FSM not idle
//   err_trunc         : one-cycle pulse when a grant is released at MAX_PKT_DW
// Optional (PCILEECH_COM_TX_ARB_STATS_EN):
//   stat_pkt_cnt      : per-source wrapping 16-bit completed-packet counters
//   stat_pad_cnt      : saturating count of PAD_DW lanes emitted
//
// state       | meaning
// ARB_IDLE    | no grant; pick next requester, takes one cycle
// ARB_COLLECT | granted source streams DWORDs into lanes
// ARB_EMIT    | padded word presented, written when out_ready
// ---------------------------------------------------------------------------
module pcileech_com_tx_arb
  import pcileech_com_pkg::*;
#(
  parameter int      NUM_SRC     = 4,
  parameter com_dw_t PAD_DW      = COM_PAD_DW,
  parameter int      MAX_PKT_DW  = 4096,
  parameter int      TIMEOUT_CYC = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  pcileech_com_tx_arb_if.slave   bus,
  output logic [2:0]             grant_idx,
  output logic                   busy,
  output logic                   err_trunc
`ifdef PCILEECH_COM_TX_ARB_STATS_EN
  ,
  output logic [NUM_SRC*16-1:0]  stat_pkt_cnt,
  output logic [31:0]            stat_pad_cnt
`endif
);

  localparam int IDLE_W = $clog2(TIMEOUT_CYC + 1);

  arb_state_t                        state_q, state_d;
  logic [2:0]                        grant_q, grant_d;
  logic [2:0]                        last_grant_q, last_grant_d;
  // bit 3 is the full flag: all eight lanes written
  logic [3:0]                        dw_cnt_q, dw_cnt_d;
  logic [12:0]                       pkt_cnt_q, pkt_cnt_d;
  logic [IDLE_W-1:0]                 idle_cnt_q, idle_cnt_d;
  logic                              pkt_end_q, pkt_end_d;
  logic                              err_trunc_q, err_trunc_d;
  logic [COM_WORD_DW-1:0][31:0]      lanes_q, lanes_d;

  logic [COM_WORD_DW-1:0][31:0]      pad_word;
  logic [NUM_SRC*32-1:0]             src_shift;
  com_dw_t                           sel_data;
  logic                              sel_valid;
  logic                              sel_last;
  logic [2:0]                        pick_idx;
  logic                              pick_any;

  pcileech_rr_pick #(
    .N  (NUM_SRC),
    .IW (3)
  ) u_pick (
    .req_i  (bus.src_valid),
    .last_i (last_grant_q),
    .idx_o  (pick_idx),
    .any_o  (pick_any)
  );

  assign src_shift = bus.src_data >> {grant_q, 5'd0};
  assign sel_data  = src_shift[31:0];
  assign sel_valid = |(bus.src_valid & (NUM_SRC'(1) << grant_q));
  assign sel_last  = |(bus.src_last  & (NUM_SRC'(1) << grant_q));

  always_comb begin
    for (int k = 0; k < COM_WORD_DW; k++) begin
      pad_word[k] = (4'(k) < dw_cnt_q) ? lanes_q[k] : PAD_DW;
    end
  end

  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    last_grant_d  = last_grant_q;
    dw_cnt_d      = dw_cnt_q;
    pkt_cnt_d     = pkt_cnt_q;
    idle_cnt_d    = idle_cnt_q;
    pkt_end_d     = pkt_end_q;
    err_trunc_d   = 1'b0;
    lanes_d       = lanes_q;
    bus.src_ready = '0;
    bus.out_wr_en = 1'b0;
    bus.out_data  = '0;

    unique case (state_q)
      ARB_IDLE: begin
        if (pick_any) begin
          grant_d    = pick_idx;
          dw_cnt_d   = '0;
          pkt_cnt_d  = '0;
          idle_cnt_d = '0;
          pkt_end_d  = 1'b0;
          state_d    = ARB_COLLECT;
        end
      end

      ARB_COLLECT: begin
        bus.src_ready = NUM_SRC'(1) << grant_q;
        if (sel_valid) begin
          lanes_d[dw_cnt_q[2:0]] = sel_data;
          dw_cnt_d   = dw_cnt_q + 4'd1;
          pkt_cnt_d  = pkt_cnt_q + 13'd1;
          idle_cnt_d = '0;
          if (sel_last) begin
            pkt_end_d = 1'b1;
            state_d   = ARB_EMIT;
          end else if (pkt_cnt_d == 13'(MAX_PKT_DW)) begin
            pkt_end_d   = 1'b1;
            err_trunc_d = 1'b1;
            state_d     = ARB_EMIT;
          end else if (dw_cnt_d[3]) begin
            state_d = ARB_EMIT;
          end
        end else begin
          // Saturate so an empty word never flushes and the counter never wraps.
          if (idle_cnt_q != IDLE_W'(TIMEOUT_CYC)) begin
            idle_cnt_d = idle_cnt_q + IDLE_W'(1);
          end
          if ((idle_cnt_d == IDLE_W'(TIMEOUT_CYC)) && (dw_cnt_q != 4'd0)) begin
            state_d = ARB_EMIT;
          end
        end
      end

      ARB_EMIT: begin
        bus.out_data  = pad_word;
        bus.out_wr_en = bus.out_ready;
        if (bus.out_ready) begin
          if (pkt_end_q) begin
            last_grant_d = grant_q;
            state_d      = ARB_IDLE;
          end else begin
            dw_cnt_d   = '0;
            idle_cnt_d = '0;
            state_d    = ARB_COLLECT;
          end
        end
      end

      default: state_d = ARB_IDLE;
    endcase

    // A reset cycle must neither accept a DWORD nor write a partial word.
    if (rst) begin
      bus.src_ready = '0;
      bus.out_wr_en = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ARB_IDLE;
      grant_q      <= '0;
      last_grant_q <= 3'(NUM_SRC - 1);
      dw_cnt_q     <= '0;
      pkt_cnt_q    <= '0;
      idle_cnt_q   <= '0;
      pkt_end_q    <= 1'b0;
      err_trunc_q  <= 1'b0;
      lanes_q      <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      dw_cnt_q     <= dw_cnt_d;
      pkt_cnt_q    <= pkt_cnt_d;
      idle_cnt_q   <= idle_cnt_d;
      pkt_end_q    <= pkt_end_d;
      err_trunc_q  <= err_trunc_d;
      lanes_q      <= lanes_d;
    end
  end

  assign grant_idx = grant_q;
  assign busy      = (state_q != ARB_IDLE);
  assign err_trunc = err_trunc_q;

`ifdef PCILEECH_COM_TX_ARB_STATS_EN
  logic [NUM_SRC-1:0][15:0] stat_pkt_q;
  logic [31:0]              stat_pad_q;
  logic [32:0]              pad_sum;

  assign pad_sum = {1'b0, stat_pad_q} + 33'(4'd8 - dw_cnt_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      stat_pkt_q <= '0;
      stat_pad_q <= '0;
    end else if (bus.out_wr_en) begin
      stat_pad_q <= pad_sum[32] ? 32'hFFFF_FFFF : pad_sum[31:0];
      for (int i = 0; i < NUM_SRC; i++) begin
        if (pkt_end_q && (grant_q == 3'(i))) begin
          stat_pkt_q[i] <= stat_pkt_q[i] + 16'd1;
        end
      end
    end
  end

  assign stat_pkt_cnt = stat_pkt_q;
  assign stat_pad_cnt = stat_pad_q;
`endif

endmodule
